// File: rtl/booth_mult_datapath.sv
// Sequential radix-2 Booth signed multiplier datapath.
// One Booth step per enabled cycle; the product is registered and held after the final step.
module booth_mult_datapath #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_enb,
   input  logic                 i_clr,
   input  logic [WIDTH-1:0]     i_multiplicand,
   input  logic [WIDTH-1:0]     i_multiplier,
   output logic                 o_ovf,
   output logic                 o_busy,
   output logic [2*WIDTH-1:0]   o_product
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] FULL = CW'(WIDTH);

   logic signed [WIDTH:0]  acc;
   logic signed [WIDTH:0]  mcand;
   logic [WIDTH-1:0]       mplier;
   logic                   q_m1;
   logic [CW-1:0]          cnt;
   logic                   ovf;
   logic                   loaded;
   logic [2*WIDTH-1:0]     product;

   logic [2*WIDTH+1:0]     step_nxt;
   logic signed [WIDTH:0]  acc_nxt;
   logic [WIDTH-1:0]       mplier_nxt;
   logic                   q_m1_nxt;
   logic                   step;

   // Add/subtract M by the {Q[0],q_m1} pair, then arithmetic-shift {A,Q,q_m1} right by one.
   function automatic logic [2*WIDTH+1:0] booth_step(
      input logic signed [WIDTH:0] a,
      input logic signed [WIDTH:0] m,
      input logic [WIDTH-1:0]      q,
      input logic                  qm
   );
      logic signed [WIDTH:0] sum;
      logic [2*WIDTH+1:0]    cat;
      case ({q[0], qm})
         2'b01:   sum = a + m;
         2'b10:   sum = a - m;
         default: sum = a;
      endcase
      cat = {sum, q, qm};
      return {cat[2*WIDTH+1], cat[2*WIDTH+1:1]};
   endfunction

   assign step_nxt   = booth_step(acc, mcand, mplier, q_m1);
   assign acc_nxt    = $signed(step_nxt[2*WIDTH+1:WIDTH+1]);
   assign mplier_nxt = step_nxt[WIDTH:1];
   assign q_m1_nxt   = step_nxt[0];
   assign step       = i_enb && (cnt < FULL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         ovf     <= 1'b0;
         loaded  <= 1'b0;
         product <= '0;
      end else if (i_clr) begin
         acc     <= '0;
         mplier  <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         ovf     <= 1'b0;
         loaded  <= 1'b0;
      end else if (i_start) begin
         mcand   <= {i_multiplicand[WIDTH-1], i_multiplicand};
         mplier  <= i_multiplier;
         acc     <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         ovf     <= 1'b0;
         loaded  <= 1'b1;
      end else if (step) begin
         acc     <= acc_nxt;
         mplier  <= mplier_nxt;
         q_m1    <= q_m1_nxt;
         cnt     <= cnt + 1'b1;
         // The extra accumulator bit is redundant sign once all steps are done.
         if (cnt == LAST) begin
            ovf     <= 1'b1;
            product <= {acc_nxt[WIDTH-1:0], mplier_nxt};
         end
      end
   end

   assign o_ovf     = ovf;
   assign o_busy    = (loaded || (cnt != '0)) && !ovf;
   assign o_product = product;

endmodule

// File: tb/tb_booth_mult_datapath.sv
// Scoreboard bench for booth_mult_datapath: driver queues exact signed products,
// a monitor pops one on every rising o_ovf and compares the registered product.
module tb_booth_mult_datapath;

   localparam int W = 8;

   logic              clk;
   logic              rst;
   logic              i_start;
   logic              i_enb;
   logic              i_clr;
   logic [W-1:0]      i_multiplicand;
   logic [W-1:0]      i_multiplier;
   logic              o_ovf;
   logic              o_busy;
   logic [2*W-1:0]    o_product;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [2*W-1:0] sb[$];

   booth_mult_datapath #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (i_start),
      .i_enb          (i_enb),
      .i_clr          (i_clr),
      .i_multiplicand (i_multiplicand),
      .i_multiplier   (i_multiplier),
      .o_ovf          (o_ovf),
      .o_busy         (o_busy),
      .o_product      (o_product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic signed [W-1:0] m,
                                               input logic signed [W-1:0] q);
      int p;
      p = int'(m) * int'(q);
      return p[2*W-1:0];
   endfunction

   // Monitor: every rising o_ovf delivers one product from the scoreboard.
   initial begin
      logic prev;
      logic [2*W-1:0] exp;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (o_ovf && !prev) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL sb_unexpected: got product %0h with empty queue", o_product);
            end else begin
               exp = sb.pop_front();
               check("product", 32'(o_product), 32'(exp));
            end
         end
         prev = o_ovf;
      end
   end

   task automatic do_start(input logic [W-1:0] m, input logic [W-1:0] q);
      i_multiplicand = m;
      i_multiplier   = q;
      i_start        = 1'b1;
      i_enb          = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      check("start_ovf", 32'(o_ovf), 32'd0);
      check("start_busy", 32'(o_busy), 32'd1);
   endtask

   task automatic run_steps(input int n, input bit gaps);
      int done;
      bit e;
      done = 0;
      while (done < n) begin
         e = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
         i_enb = e;
         @(negedge clk);
         if (e) done++;
         check("ovf_latency", 32'(o_ovf), 32'(done >= W));
         check("busy", 32'(o_busy), 32'(done < W));
      end
      i_enb = 1'b0;
   endtask

   task automatic full_run(input logic [W-1:0] m, input logic [W-1:0] q, input bit gaps);
      logic [2*W-1:0] exp;
      exp = ref_prod(m, q);
      sb.push_back(exp);
      do_start(m, q);
      run_steps(W, gaps);
      i_enb = 1'b1;
      @(negedge clk);
      i_enb = 1'b0;
      check("extra_enb_ovf", 32'(o_ovf), 32'd1);
      check("extra_enb_hold", 32'(o_product), 32'(exp));
   endtask

   task automatic pulse_clr();
      i_clr = 1'b1;
      @(negedge clk);
      i_clr = 1'b0;
   endtask

   initial begin
      logic [2*W-1:0] held;
      rst = 1'b0;
      i_start = 1'b0;
      i_enb = 1'b0;
      i_clr = 1'b0;
      i_multiplicand = '0;
      i_multiplier = '0;
      repeat (2) @(negedge clk);
      check("rst_ovf", 32'(o_ovf), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_product", 32'(o_product), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      full_run(8'd3, 8'd5, 1'b0);
      full_run(8'h80, 8'h80, 1'b0);
      full_run(8'h80, 8'd127, 1'b0);
      full_run(8'd127, 8'hFF, 1'b0);
      full_run(8'hF9, 8'd9, 1'b1);

      // Clear in the READY phase keeps the product.
      full_run(8'd3, 8'd5, 1'b0);
      pulse_clr();
      check("clr_ovf", 32'(o_ovf), 32'd0);
      check("clr_busy", 32'(o_busy), 32'd0);
      check("clr_product", 32'(o_product), 32'h000F);
      full_run(8'd2, 8'd2, 1'b0);

      // Restart after four steps.
      do_start(8'd11, 8'd13);
      run_steps(4, 1'b0);
      full_run(8'd6, 8'd7, 1'b0);

      // Clear after three steps: nothing completes.
      held = o_product;
      do_start(8'd5, 8'd5);
      run_steps(3, 1'b0);
      pulse_clr();
      repeat (10) begin
         @(negedge clk);
         check("midclr_ovf", 32'(o_ovf), 32'd0);
         check("midclr_busy", 32'(o_busy), 32'd0);
      end
      check("midclr_product", 32'(o_product), 32'(held));

      // Start and clear together: clear wins.
      i_start = 1'b1;
      i_clr = 1'b1;
      i_multiplicand = 8'd9;
      i_multiplier = 8'd9;
      @(negedge clk);
      i_start = 1'b0;
      i_clr = 1'b0;
      check("clr_start_busy", 32'(o_busy), 32'd0);

      // Asynchronous reset during step five.
      do_start(8'd3, 8'd5);
      run_steps(4, 1'b0);
      i_enb = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_ovf", 32'(o_ovf), 32'd0);
      check("arst_busy", 32'(o_busy), 32'd0);
      check("arst_product", 32'(o_product), 32'd0);
      @(negedge clk);
      i_enb = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      full_run(8'd3, 8'd5, 1'b0);

      for (int i = 0; i < 16; i++) begin
         full_run(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
